// File: rtl/program_loader_pkg.sv
// Shared loader definitions: state encoding, header geometry and header validation.
package program_loader_pkg;

   typedef enum logic [2:0] {
      LD_HDR,
      LD_DATA,
      LD_CSUM,
      LD_DONE,
      LD_ERR
   } ld_state_t;

   localparam int unsigned LD_HDR_BYTES = 4;

   // A header is usable when it announces at least one word and no more than the memory holds.
   function automatic logic header_ok(input logic [31:0] n, input int unsigned max_words);
      return (n != '0) && (n <= max_words);
   endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Little-endian byte-to-word assembler; word_valid/word are presented combinationally with the 4th byte.
module byte_assembler
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        valid,
   input  logic [7:0]  data,
   output logic [1:0]  idx,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  idx_q;
   logic [23:0] shift_q;

   assign idx        = idx_q;
   assign word_valid = valid && (idx_q == 2'(LD_HDR_BYTES - 1));
   assign word       = {data, shift_q};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else if (valid) begin
         idx_q   <= idx_q + 2'd1;
         shift_q <= {data, shift_q[23:8]};
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and writes it into instruction memory.
module program_loader
   import program_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        load_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        error
);

   localparam int unsigned IW = $clog2(MAX_WORDS + 1);

   ld_state_t   state, state_n;
   logic [31:0] count;
   logic [IW-1:0] word_idx;
   logic [31:0] word_idx32;
   logic [7:0]  csum;
   logic        accept;
   logic        asm_valid;
   logic [1:0]  byte_idx;
   logic        word_valid;
   logic [31:0] word;
   logic        last_word;

   assign rx_ready   = (state == LD_HDR) || (state == LD_DATA) || (state == LD_CSUM);
   // load_req wins over a simultaneous byte, so the byte is dropped rather than consumed.
   assign accept     = rx_valid && rx_ready && !load_req;
   assign asm_valid  = accept && ((state == LD_HDR) || (state == LD_DATA));
   assign word_idx32 = 32'(word_idx);
   assign last_word  = (word_idx32 == (count - 32'd1));

   byte_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (load_req),
      .valid      (asm_valid),
      .data       (rx_data),
      .idx        (byte_idx),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      state_n = state;
      if (load_req) begin
         state_n = LD_HDR;
      end else begin
         case (state)
            LD_HDR:  if (word_valid) state_n = header_ok(word, MAX_WORDS) ? LD_DATA : LD_ERR;
            LD_DATA: if (word_valid && last_word) state_n = LD_CSUM;
            LD_CSUM: if (accept) state_n = (rx_data == csum) ? LD_DONE : LD_ERR;
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LD_HDR;
         count     <= '0;
         word_idx  <= '0;
         csum      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         done      <= (state_n == LD_DONE);
         error     <= (state_n == LD_ERR);
         cpu_reset <= (state_n != LD_DONE);
         mem_we    <= 1'b0;
         if (load_req) begin
            count    <= '0;
            word_idx <= '0;
            csum     <= '0;
         end else if (accept) begin
            case (state)
               LD_HDR: count[{byte_idx, 3'b000} +: 8] <= rx_data;
               LD_DATA: begin
                  csum <= csum ^ rx_data;
                  if (word_valid) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= BASE_ADDR + (word_idx32 << 2);
                     mem_wdata <= word;
                     word_idx  <= word_idx + IW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a stream-level model predicts writes and final status for two base addresses.
module tb_program_loader;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_0100;
   localparam longint      MAXW  = 1024;

   logic clk = 1'b0;
   logic reset, rx_valid, load_req;
   logic [7:0] rx_data;
   logic rx_ready0, mem_we0, cpu_reset0, done0, error0;
   logic rx_ready1, mem_we1, cpu_reset1, done1, error1;
   logic [31:0] mem_addr0, mem_wdata0, mem_addr1, mem_wdata1;

   int total = 0;
   int bad = 0;
   logic [63:0] exp0[$], exp1[$], act0[$], act1[$];
   logic m_done, m_err;
   logic pre_done;

   always #5 clk = ~clk;

   program_loader #(.BASE_ADDR(BASE0), .MAX_WORDS(1024)) u_dut0 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready0),
      .load_req(load_req), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .cpu_reset(cpu_reset0), .done(done0), .error(error0)
   );

   program_loader #(.BASE_ADDR(BASE1), .MAX_WORDS(1024)) u_dut1 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready1),
      .load_req(load_req), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .cpu_reset(cpu_reset1), .done(done1), .error(error1)
   );

   // Per-cycle compare: every write strobe must match the next predicted write, in order.
   always @(posedge clk) begin
      logic [63:0] e;
      #1;
      if (mem_we0) begin
         total++;
         if (exp0.size() == 0) begin
            bad++;
            $display("FAIL wr0_unexpected got addr=%h data=%h exp none", mem_addr0, mem_wdata0);
         end else begin
            e = exp0.pop_front();
            if ({mem_addr0, mem_wdata0} !== e) begin
               bad++;
               $display("FAIL wr0 got %h_%h exp %h_%h", mem_addr0, mem_wdata0, e[63:32], e[31:0]);
            end
         end
         act0.push_back({mem_addr0, mem_wdata0});
      end
      if (mem_we1) begin
         total++;
         if (exp1.size() == 0) begin
            bad++;
            $display("FAIL wr1_unexpected got addr=%h data=%h exp none", mem_addr1, mem_wdata1);
         end else begin
            e = exp1.pop_front();
            if ({mem_addr1, mem_wdata1} !== e) begin
               bad++;
               $display("FAIL wr1 got %h_%h exp %h_%h", mem_addr1, mem_wdata1, e[63:32], e[31:0]);
            end
         end
         act1.push_back({mem_addr1, mem_wdata1});
      end
      total++;
      if ((cpu_reset0 !== ~done0) || (done0 && error0)) begin
         bad++;
         $display("FAIL status0 got cpu_reset=%b done=%b error=%b exp cpu_reset=!done and not done&error",
                  cpu_reset0, done0, error0);
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, expv);
      end
   endtask

   // Stream-level model: parse whatever bytes were delivered and predict writes and outcome.
   task automatic model(input logic [7:0] b[$]);
      longint n, avail, nw;
      logic [7:0] x;
      logic [31:0] d;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (b.size() < 4) return;
      n = longint'({b[3], b[2], b[1], b[0]});
      if (n == 0 || n > MAXW) begin
         m_err = 1'b1;
         return;
      end
      avail = longint'((b.size() - 4) / 4);
      nw = (avail < n) ? avail : n;
      for (int k = 0; k < nw; k++) begin
         d = {b[4*k+7], b[4*k+6], b[4*k+5], b[4*k+4]};
         exp0.push_back({BASE0 + 32'(4*k), d});
         exp1.push_back({BASE1 + 32'(4*k), d});
      end
      if (longint'(b.size()) > 4 + 4*n) begin
         x = 8'h00;
         for (int j = 4; j < 4 + 4*n; j++) x ^= b[j];
         m_done = (x == b[4 + 4*n]);
         m_err  = ~m_done;
      end
   endtask

   // Returns just after the edge that transfers the last byte.
   task automatic send(input logic [7:0] b[$], input bit throttle);
      int i = 0;
      int guard = 0;
      bit take;
      while (i < b.size()) begin
         @(negedge clk);
         rx_valid = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
         rx_data  = b[i];
         take = rx_valid && rx_ready0;
         if (i == b.size() - 1) pre_done = done0;
         @(posedge clk);
         if (take) i++;
         guard++;
         if (guard > 2000) begin
            total++;
            bad++;
            $display("FAIL send_timeout got sent=%0d exp sent=%0d", i, b.size());
            break;
         end
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      rx_valid = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_load();
      @(negedge clk);
      rx_valid = 1'b0;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      check("after_load_req", {rx_ready0, done0, error0, cpu_reset0, rx_ready1}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
   endtask

   task automatic chk_status(input string name);
      check({name, "_status0"}, {done0, error0, cpu_reset0, rx_ready0}, {m_done, m_err, ~m_done, ~(m_done | m_err)});
      check({name, "_status1"}, {done1, error1, cpu_reset1, rx_ready1}, {m_done, m_err, ~m_done, ~(m_done | m_err)});
   endtask

   task automatic chk_drained(input string name);
      check({name, "_pending0"}, 64'(exp0.size()), 64'd0);
      check({name, "_pending1"}, 64'(exp1.size()), 64'd0);
   endtask

   task automatic chk_reset_vals(input string name);
      check({name, "_0"}, {mem_we0, mem_addr0, mem_wdata0, cpu_reset0, done0, error0, rx_ready0},
            {1'b0, BASE0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
      check({name, "_1"}, {mem_we1, mem_addr1, mem_wdata1, cpu_reset1, done1, error1, rx_ready1},
            {1'b0, BASE1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got running exp finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] img[$];
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      load_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      @(negedge clk);
      reset = 1'b0;

      // Full-rate two-word image; payload XOR is 0x90.
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      act0.delete(); act1.delete();
      model(img);
      send(img, 1'b0);
      #1;
      check("t1_done_before_csum", 64'(pre_done), 64'd0);
      check("t1_done_lit", {done0, cpu_reset0, error0}, {1'b1, 1'b0, 1'b0});
      chk_status("t1");
      idle_cycle();
      chk_status("t1_idle");
      chk_drained("t1");
      check("t1_nwr", 64'(act0.size()), 64'd2);
      check("t1_wr0_lit", act0[0], {32'h0, 32'h0000_0013});
      check("t1_wr1_lit", act0[1], {32'h4, 32'h0010_0093});
      check("t1_base1_lit", act1[0], {32'h100, 32'h0000_0013});

      // Same image, corrupted checksum.
      pulse_load();
      img[12] = 8'h91;
      model(img);
      send(img, 1'b0);
      #1;
      check("t2_err_lit", {error0, cpu_reset0, done0}, {1'b1, 1'b1, 1'b0});
      chk_status("t2");
      idle_cycle();
      chk_drained("t2");

      // Zero-length header.
      pulse_load();
      act0.delete();
      img = '{8'h00, 8'h00, 8'h00, 8'h00};
      model(img);
      send(img, 1'b0);
      #1;
      check("t3_err_lit", {error0, rx_ready0}, {1'b1, 1'b0});
      chk_status("t3");

      // N = 1025, one beyond the limit.
      pulse_load();
      img = '{8'h01, 8'h04, 8'h00, 8'h00};
      model(img);
      send(img, 1'b0);
      #1;
      check("t4_err_lit", {error0, rx_ready0}, {1'b1, 1'b0});
      chk_status("t4");
      idle_cycle();
      check("t3t4_nwr", 64'(act0.size()), 64'd0);

      // Throttled three-word image; checksum 0x22.
      pulse_load();
      act0.delete();
      img = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01,
              8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h22};
      model(img);
      send(img, 1'b1);
      #1;
      chk_status("t5");
      idle_cycle();
      chk_drained("t5");
      check("t5_nwr", 64'(act0.size()), 64'd3);
      check("t5_wr2_lit", act0[2], {32'h8, 32'hA5A5_A5A5});
      check("t5_done_lit", 64'(done0), 64'd1);

      // Abort after six payload bytes, then a one-word image.
      pulse_load();
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      model(img);
      send(img, 1'b0);
      pulse_load();
      idle_cycle();
      chk_drained("t6_abort");
      act0.delete(); act1.delete();
      img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25};
      model(img);
      send(img, 1'b0);
      #1;
      chk_status("t6");
      idle_cycle();
      chk_drained("t6");
      check("t6_nwr", 64'(act0.size()), 64'd1);
      check("t6_wr_lit", act0[0], {32'h0, 32'h0000_1237});

      // Reset in the middle of DATA, then a fresh image.
      pulse_load();
      img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      model(img);
      send(img, 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("t7_reset");
      @(negedge clk);
      reset = 1'b0;
      idle_cycle();
      chk_drained("t7_abort");
      act0.delete(); act1.delete();
      img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      model(img);
      send(img, 1'b0);
      #1;
      chk_status("t7");
      idle_cycle();
      chk_drained("t7");
      check("t7_base1_lit", act1[0], {32'h100, 32'h1234_5678});
      check("t7_nwr", 64'(act1.size()), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
